fifo_demux2: RTL and testbench

Two-way stream demultiplexer for the backpropagation datapath: one word from the `data` stream is routed to output stream `a` or `b`, as chosen by a paired word on the `select` stream. It is the splitting counterpart of `fifo_mux2` and is used wherever one producer (e.g. an error or weight stream) must feed one of two consumers. Each output has a 2-entry buffer, so one output stalling never blocks words already bound for the other, and steady streaming runs at one word per cycle.

---
 rtl/fifo_demux2_pkg.sv | 18 +
 rtl/fifo_demux2_fifo2.sv | 83 ++++++++
 rtl/fifo_demux2.sv | 65 ++++++
 tb/tb_fifo_demux2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_demux2_pkg.sv
// Shared constants and helpers for the two-way stream demultiplexer.
// Both the top level and the 2-entry output buffers import this package.
package fifo_demux2_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int FIFO_DEPTH  = 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef logic [1:0] fifo_cnt_t;

    // A buffer can take another word while it holds fewer than FIFO_DEPTH entries.
    function automatic logic fifo_has_space(input fifo_cnt_t cnt);
        return cnt < fifo_cnt_t'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_demux2_fifo2.sv
// Two-entry valid/ready buffer whose head word and valid come straight from flops.
// The caller only asserts in_valid while count is below two.
module fifo2
    import fifo_demux2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    fifo_cnt_t        cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             push;
    logic             pop;

    assign push = in_valid;
    assign pop  = valid_q & out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = in_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d = in_data;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    // An empty buffer presents zero on its data output.
                    head_d = '0;
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop && push) begin
                    head_d = tail_q;
                    tail_d = in_data;
                end else if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    cnt_d  = 2'd1;
                end
            end
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = head_q;
    assign out_valid = valid_q;
    assign count     = cnt_q;

endmodule

// File: rtl/fifo_demux2.sv
// Routes each data word to output a or b according to its paired select word.
// Readies depend only on buffer occupancy and partner valid, never on a_ready/b_ready.
module fifo_demux2
    import fifo_demux2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             select,
    input  logic             select_valid,
    output logic             select_ready,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    input  logic             b_ready
);

    logic [1:0] count_a;
    logic [1:0] count_b;
    logic       space_sel;
    logic       pair_ok;
    logic       accept;
    logic       push_a;
    logic       push_b;

    assign space_sel = (select == SEL_B) ? fifo_has_space(count_b) : fifo_has_space(count_a);

    // Gating with rst_n keeps both readies low while reset is held.
    assign pair_ok      = rst_n & space_sel;
    assign data_ready   = select_valid & pair_ok;
    assign select_ready = data_valid & pair_ok;

    assign accept = data_valid & select_valid & pair_ok;
    assign push_a = accept & (select == SEL_A);
    assign push_b = accept & (select == SEL_B);

    fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (data),
        .in_valid  (push_a),
        .out_data  (a),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .count     (count_a)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (data),
        .in_valid  (push_b),
        .out_data  (b),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .count     (count_b)
    );

endmodule

// File: tb/tb_fifo_demux2.sv
// Directed bench for fifo_demux2: steering, pairing, backpressure, independence,
// streaming and asynchronous reset, with hand-computed expectations.
module tb_fifo_demux2;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data;
    logic         data_valid;
    logic         data_ready;
    logic         select;
    logic         select_valid;
    logic         select_ready;
    logic [W-1:0] a;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b;
    logic         b_valid;
    logic         b_ready;

    int tests_run;
    int tests_failed;

    fifo_demux2 #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .select       (select),
        .select_valid (select_valid),
        .select_ready (select_ready),
        .a            (a),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b            (b),
        .b_valid      (b_valid),
        .b_ready      (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_valid   = 1'b0;
        select_valid = 1'b0;
        data         = '0;
        select       = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic s);
        data         = d;
        select       = s;
        data_valid   = 1'b1;
        select_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        send(32'd5, 1'b0);
        #3;
        tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
        tests_run++; if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
        tests_run++; if (a !== 32'd0) begin tests_failed++; $display("FAIL reset_a: got %0d want 0", a); end
        tests_run++; if (b !== 32'd0) begin tests_failed++; $display("FAIL reset_b: got %0d want 0", b); end
        tests_run++; if (data_ready !== 1'b0 || select_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_readies: got %b%b want 00", data_ready, select_ready); end
        tick();
        tick();
        tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_no_push: got a_valid %b want 0", a_valid); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_steer_a();
        a_ready = 1'b1;
        send(32'd100, 1'b0);
        #1;
        tests_run++; if (data_ready !== 1'b1 || select_ready !== 1'b1) begin tests_failed++; $display("FAIL steer_readies: got %b%b want 11", data_ready, select_ready); end
        tick();
        idle_inputs();
        tests_run++; if (a !== 32'd100 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL steer_a_out: got %0d/%b want 100/1", a, a_valid); end
        tests_run++; if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL steer_b_quiet: got %b want 0", b_valid); end
        tick();
        tests_run++; if (a_valid !== 1'b0 || a !== 32'd0) begin tests_failed++; $display("FAIL steer_a_drained: got %0d/%b want 0/0", a, a_valid); end
    endtask

    task automatic test_missing_partner();
        b_ready = 1'b0;
        data = 32'd256;
        data_valid = 1'b1;
        select = 1'b1;
        select_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL partner_data_ready cycle %0d: got %b want 0", i, data_ready); end
            tick();
            tests_run++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin tests_failed++; $display("FAIL partner_no_output cycle %0d: got %b%b want 00", i, a_valid, b_valid); end
        end
        select_valid = 1'b1;
        #1;
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL partner_joined_ready: got %b want 1", data_ready); end
        tick();
        idle_inputs();
        tests_run++; if (b !== 32'd256 || b_valid !== 1'b1) begin tests_failed++; $display("FAIL partner_b_out: got %0d/%b want 256/1", b, b_valid); end
        tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL partner_a_quiet: got %b want 0", a_valid); end
        b_ready = 1'b1;
        tick();
        tests_run++; if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL partner_b_drained: got %b want 0", b_valid); end
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0;
        send(32'd100, 1'b0);
        tick();
        send(32'd101, 1'b0);
        #1;
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_second_ready: got %b want 1", data_ready); end
        tick();
        send(32'd102, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (data_ready !== 1'b0 || select_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_readies cycle %0d: got %b%b want 00", i, data_ready, select_ready); end
            tests_run++; if (a !== 32'd100 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_head_hold cycle %0d: got %0d/%b want 100/1", i, a, a_valid); end
            tick();
        end
        a_ready = 1'b1;
        #1;
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_no_downstream_path: got %b want 0", data_ready); end
        tick();
        tests_run++; if (a !== 32'd101 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_order_1: got %0d/%b want 101/1", a, a_valid); end
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_back: got %b want 1", data_ready); end
        tick();
        idle_inputs();
        tests_run++; if (a !== 32'd102 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_order_2: got %0d/%b want 102/1", a, a_valid); end
        tick();
        tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %b want 0", a_valid); end
    endtask

    task automatic test_independence();
        a_ready = 1'b0;
        b_ready = 1'b0;
        send(32'd1, 1'b0);
        tick();
        send(32'd2, 1'b0);
        tick();
        #1;
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL indep_a_full: got %b want 0", data_ready); end
        send(32'd256, 1'b1);
        #1;
        tests_run++; if (data_ready !== 1'b1 || select_ready !== 1'b1) begin tests_failed++; $display("FAIL indep_b_ready: got %b%b want 11", data_ready, select_ready); end
        tick();
        idle_inputs();
        tests_run++; if (b !== 32'd256 || b_valid !== 1'b1) begin tests_failed++; $display("FAIL indep_b_out: got %0d/%b want 256/1", b, b_valid); end
        tests_run++; if (a !== 32'd1 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL indep_a_held: got %0d/%b want 1/1", a, a_valid); end
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        tests_run++; if (a !== 32'd2 || b_valid !== 1'b0) begin tests_failed++; $display("FAIL indep_drain: got a %0d b_valid %b want 2/0", a, b_valid); end
        tick();
        tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL indep_a_empty: got %b want 0", a_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] word;
        logic         s;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            word = 32'd200 + 32'(i);
            s = (i % 2) == 1;
            send(word, s);
            #1;
            tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready word %0d: got %b want 1", i, data_ready); end
            tick();
            if (!s) begin
                tests_run++; if (a !== word || a_valid !== 1'b1 || b_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_a word %0d: got %0d/%b b_valid %b want %0d/1/0", i, a, a_valid, b_valid, word); end
            end else begin
                tests_run++; if (b !== word || b_valid !== 1'b1 || a_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_b word %0d: got %0d/%b a_valid %b want %0d/1/0", i, b, b_valid, a_valid, word); end
            end
        end
        idle_inputs();
        tick();
        tests_run++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drained: got %b%b want 00", a_valid, b_valid); end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0;
        send(32'd50, 1'b0);
        tick();
        send(32'd51, 1'b0);
        tick();
        idle_inputs();
        tests_run++; if (a !== 32'd50 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_filled: got %0d/%b want 50/1", a, a_valid); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (a_valid !== 1'b0 || a !== 32'd0) begin tests_failed++; $display("FAIL rmid_async_clear: got %0d/%b want 0/0", a, a_valid); end
        #1;
        rst_n = 1'b1;
        send(32'd77, 1'b0);
        #1;
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_ready: got %b want 1", data_ready); end
        tick();
        idle_inputs();
        tests_run++; if (a !== 32'd77 || a_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_first_word: got %0d/%b want 77/1", a, a_valid); end
        a_ready = 1'b1;
        tick();
        tests_run++; if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_single: got %b want 0", a_valid); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_steer_a();
        test_missing_partner();
        test_backpressure();
        test_independence();
        test_streaming();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
